// File: rtl/inst_data_mem_arbiter_pkg.sv
// Shared encodings for the instruction/data memory-port arbiter.
// FSM states, owner select and transfer-size codes used by the top and the grant selector.
package inst_data_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/arb_grant_sel.sv
// Priority select between data and inst requesters; data wins unless inst is starved.
// Optional macro FAIR_ARB_EN adds a saturating starve counter that forces an inst grant.
module arb_grant_sel #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic grant_en,
   input  logic inst_req,
   input  logic data_req,
   output logic grant_data,
   output logic grant_inst
);

`ifdef FAIR_ARB_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_q, starve_d;
   logic             force_inst;

   // Counts data grants taken while inst waits; saturates at CNT_MAX.
   always_comb begin
      force_inst = (starve_q == CNT_MAX);
      grant_inst = inst_req & (~data_req | force_inst);
      grant_data = data_req & ~grant_inst;
      starve_d   = starve_q;
      if (grant_en && grant_inst) begin
         starve_d = '0;
      end else if (grant_en && grant_data && inst_req) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= '0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   logic unused_fair;
   assign unused_fair = ^{clk, rst, grant_en};

   always_comb begin
      grant_data = data_req;
      grant_inst = inst_req & ~data_req;
   end
`endif

endmodule

// File: rtl/inst_data_mem_arbiter.sv
// Shares one sram-like memory port between instruction fetch and data access, one transaction at a time.
// Optional macro FAIR_ARB_EN enables starvation protection for the fetch side.
module inst_data_mem_arbiter
   import inst_data_mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   state_e state_q, state_d;
   owner_e owner_q, owner_d;
   logic   grant_data, grant_inst;
   logic   own_req;

   arb_grant_sel #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_grant_sel (
      .clk        (clk),
      .rst        (rst),
      .grant_en   (state_q == ST_IDLE),
      .inst_req   (inst_req),
      .data_req   (data_req),
      .grant_data (grant_data),
      .grant_inst (grant_inst)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_INST;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // Next state plus owner-muxed request and response routing; outputs held at 0 during reset.
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = '0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = '0;
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_size     = SZ_BYTE;
      mem_addr     = '0;
      mem_wdata    = '0;
      own_req      = (owner_q == OWN_DATA) ? data_req : inst_req;

      if (!rst) begin
         case (state_q)
            ST_IDLE: begin
               if (grant_data) begin
                  owner_d = OWN_DATA;
                  state_d = ST_ADDR;
               end else if (grant_inst) begin
                  owner_d = OWN_INST;
                  state_d = ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (!own_req) begin
                  state_d = ST_IDLE;
               end else begin
                  mem_req = 1'b1;
                  if (owner_q == OWN_DATA) begin
                     mem_wr    = data_wr;
                     mem_size  = data_size;
                     mem_addr  = data_addr;
                     mem_wdata = data_wdata;
                  end else begin
                     mem_size  = SZ_WORD;
                     mem_addr  = inst_addr;
                  end
                  if (mem_addr_ok) begin
                     data_addr_ok = (owner_q == OWN_DATA);
                     inst_addr_ok = (owner_q == OWN_INST);
                     state_d      = ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (mem_data_ok) begin
                  if (owner_q == OWN_DATA) begin
                     data_data_ok = 1'b1;
                     data_rdata   = mem_rdata;
                  end else begin
                     inst_data_ok = 1'b1;
                     inst_rdata   = mem_rdata;
                  end
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_data_mem_arbiter.sv
// Self-checking bench for inst_data_mem_arbiter: directed scenarios plus randomized traffic vs. a behavioural model.
// Honours FAIR_ARB_EN when the design is built with it.
module tb_inst_data_mem_arbiter;

`ifdef FAIR_ARB_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   localparam int STARVE = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   // Model state: transaction stage (0 nothing, 1 granted/awaiting accept, 2 awaiting data).
   int m_stage = 0;
   bit m_data_owns = 1'b0;
   int m_streak = 0;

   always #5 clk = ~clk;

   inst_data_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)
   ) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Predict this cycle's outputs from the inputs and the transaction in flight, then advance.
   task automatic model_compare();
      logic        e_req, e_wr, e_iaok, e_idok, e_daok, e_ddok;
      logic [1:0]  e_size;
      logic [31:0] e_addr, e_wdata, e_ird, e_drd;
      int          nstage;
      bit          inst_first, oreq;
      e_req = 0; e_wr = 0; e_size = 0; e_addr = 0; e_wdata = 0;
      e_iaok = 0; e_idok = 0; e_daok = 0; e_ddok = 0; e_ird = 0; e_drd = 0;
      nstage = m_stage;
      if (rst) begin
         nstage   = 0;
         m_streak = 0;
      end else if (m_stage == 0) begin
         inst_first = inst_req && (!data_req || (FAIR && m_streak >= STARVE));
         if (inst_first) begin
            m_data_owns = 1'b0; nstage = 1; m_streak = 0;
         end else if (data_req) begin
            m_data_owns = 1'b1; nstage = 1;
            if (FAIR && inst_req && m_streak < STARVE) m_streak++;
         end
      end else if (m_stage == 1) begin
         oreq = m_data_owns ? data_req : inst_req;
         if (!oreq) begin
            nstage = 0;
         end else begin
            e_req = 1;
            if (m_data_owns) begin
               e_wr = data_wr; e_size = data_size; e_addr = data_addr; e_wdata = data_wdata;
            end else begin
               e_size = 2'd2; e_addr = inst_addr;
            end
            if (mem_addr_ok) begin
               if (m_data_owns) e_daok = 1; else e_iaok = 1;
               nstage = 2;
            end
         end
      end else if (mem_data_ok) begin
         if (m_data_owns) begin e_ddok = 1; e_drd = mem_rdata; end
         else begin e_idok = 1; e_ird = mem_rdata; end
         nstage = 0;
      end
      m_stage = nstage;
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("mem_wr", 32'(mem_wr), 32'(e_wr));
      chk("mem_size", 32'(mem_size), 32'(e_size));
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wdata);
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
      chk("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
      chk("inst_rdata", inst_rdata, e_ird);
      chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
      chk("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
      chk("data_rdata", data_rdata, e_drd);
   endtask

   task automatic cyc_check();
      #1;
      model_compare();
   endtask

   task automatic next_cyc();
      @(negedge clk);
   endtask

   task automatic cyc();
      cyc_check();
      next_cyc();
   endtask

   task automatic quiet_inputs();
      rst = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_size = 0;
      data_addr = 0; data_wdata = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst = 1;
      cyc();
      rst = 0;
   endtask

   bit grants[$];
   bit prev_iaok, prev_daok;

   initial begin
      quiet_inputs();
      rst = 1;
      @(posedge clk);
      @(negedge clk);
      cyc_check();
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      chk("reset_mem_addr", mem_addr, 32'd0);
      next_cyc();
      rst = 0;
      cyc();

      // Single fetch
      inst_req = 1; inst_addr = 32'hBFC00000;
      cyc();
      cyc_check();
      chk("t1_mem_addr", mem_addr, 32'hBFC00000);
      chk("t1_mem_size", 32'(mem_size), 32'd2);
      next_cyc();
      mem_addr_ok = 1;
      cyc_check();
      chk("t1_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      next_cyc();
      inst_req = 0; mem_addr_ok = 0;
      cyc();
      mem_data_ok = 1; mem_rdata = 32'h24080001;
      cyc_check();
      chk("t1_inst_data_ok", 32'(inst_data_ok), 32'd1);
      chk("t1_inst_rdata", inst_rdata, 32'h24080001);
      chk("t1_data_data_ok", 32'(data_data_ok), 32'd0);
      next_cyc();
      mem_data_ok = 0;
      cyc();

      // Tie: data goes first, inst follows after one idle cycle
      do_reset();
      inst_req = 1; inst_addr = 32'hBFC00004;
      data_req = 1; data_addr = 32'h80001000; data_size = 2'd2;
      cyc();
      mem_addr_ok = 1;
      cyc_check();
      chk("t2_first_addr", mem_addr, 32'h80001000);
      chk("t2_data_addr_ok", 32'(data_addr_ok), 32'd1);
      next_cyc();
      data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11223344;
      cyc_check();
      chk("t2_data_data_ok", 32'(data_data_ok), 32'd1);
      next_cyc();
      mem_data_ok = 0;
      cyc();
      cyc_check();
      chk("t2_second_addr", mem_addr, 32'hBFC00004);
      next_cyc();
      mem_addr_ok = 1;
      cyc();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
      cyc();
      mem_data_ok = 0;

      // Store: completes only on mem_data_ok
      do_reset();
      data_req = 1; data_wr = 1; data_size = 2'd0; data_addr = 32'h80000003; data_wdata = 32'h000000AB;
      cyc();
      mem_addr_ok = 1;
      cyc_check();
      chk("t3_mem_wr", 32'(mem_wr), 32'd1);
      chk("t3_mem_size", 32'(mem_size), 32'd0);
      chk("t3_mem_wdata", mem_wdata, 32'h000000AB);
      next_cyc();
      data_req = 0; data_wr = 0; mem_addr_ok = 0;
      for (int i = 0; i < 4; i++) begin
         cyc_check();
         chk("t3_no_early_ack", 32'(data_data_ok), 32'd0);
         next_cyc();
      end
      mem_data_ok = 1;
      cyc_check();
      chk("t3_store_ack", 32'(data_data_ok), 32'd1);
      next_cyc();
      mem_data_ok = 0;

      // Reset while waiting for data
      data_req = 1; data_addr = 32'h80000010; data_size = 2'd2;
      cyc();
      mem_addr_ok = 1;
      cyc();
      data_req = 0; mem_addr_ok = 0;
      cyc();
      rst = 1; mem_data_ok = 1; mem_rdata = 32'hDEADBEEF;
      cyc_check();
      chk("t4_ok_in_rst", 32'(data_data_ok), 32'd0);
      next_cyc();
      rst = 0;
      cyc_check();
      chk("t4_ok_after_rst", 32'(data_data_ok), 32'd0);
      chk("t4_rdata_after_rst", data_rdata, 32'd0);
      next_cyc();
      mem_data_ok = 0;

      // Abort: owner drops req before accept
      inst_req = 1; inst_addr = 32'hBFC00100;
      cyc();
      inst_req = 0; mem_addr_ok = 1;
      cyc_check();
      chk("t6_mem_req_drop", 32'(mem_req), 32'd0);
      chk("t6_no_addr_ok", 32'(inst_addr_ok), 32'd0);
      next_cyc();
      cyc_check();
      chk("t6_idle_no_req", 32'(mem_req), 32'd0);
      next_cyc();
      mem_addr_ok = 0;

      // Fairness pattern under continuous demand
      do_reset();
      inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
      for (int i = 0; i < 60; i++) begin
         cyc_check();
         if (data_addr_ok) grants.push_back(1'b1);
         if (inst_addr_ok) grants.push_back(1'b0);
         next_cyc();
      end
      chk("t5_grant_count", 32'(grants.size()), 32'd20);
      for (int k = 0; k < grants.size(); k++) begin
         chk("t5_grant_owner", 32'(grants[k]), (FAIR && (k % 5 == 4)) ? 32'd0 : 32'd1);
      end

      // Randomized traffic
      do_reset();
      prev_iaok = 0; prev_daok = 0;
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if (inst_req && !prev_iaok) inst_req = ($urandom_range(0, 15) != 0);
         else inst_req = 1'($urandom_range(0, 1));
         if (data_req && !prev_daok) data_req = ($urandom_range(0, 15) != 0);
         else data_req = 1'($urandom_range(0, 1));
         inst_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
         data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 2));
         mem_addr_ok = 1'($urandom_range(0, 1));
         mem_data_ok = ($urandom_range(0, 2) == 0);
         mem_rdata = $urandom;
         cyc_check();
         prev_iaok = inst_addr_ok; prev_daok = data_addr_ok;
         next_cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
